// File: rtl/frame_tri_scheduler.sv
// frame_tri_scheduler: walks the instance table once per frame and issues one triangle job per handshake.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   frame_start, abort  start a walk / cancel the current walk
//   inst_count          valid instances including the camera (instance 0, never walked)
//   inst_rd_en/addr     instance table read; inst_tri_base/cnt return one cycle later
//   tri_valid/ready     job handshake carrying tri_inst_id, tri_idx, tri_last
//   busy, frame_done    walk in progress / one-cycle completion pulse
//   tri_issued          saturating handshake count for the current or last frame
module frame_tri_scheduler #(
    parameter int MAX_INST = 256,
    parameter int MAX_TRI_CNT = 256,
    localparam int IIDX_W = $clog2(MAX_INST),
    localparam int TIDX_W = $clog2(MAX_TRI_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              abort,
    input  logic [IIDX_W:0]   inst_count,
    output logic              inst_rd_en,
    output logic [IIDX_W-1:0] inst_rd_addr,
    input  logic [TIDX_W-1:0] inst_tri_base,
    input  logic [TIDX_W:0]   inst_tri_cnt,
    output logic              tri_valid,
    input  logic              tri_ready,
    output logic [IIDX_W-1:0] tri_inst_id,
    output logic [TIDX_W-1:0] tri_idx,
    output logic              tri_last,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       tri_issued
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
    state_t state_q, state_d;
    logic [IIDX_W:0] icnt_q, icnt_d;
    logic [IIDX_W-1:0] i_q, i_d;
    logic [TIDX_W-1:0] base_q, base_d;
    logic [TIDX_W:0] tcnt_q, tcnt_d, k_q, k_d;
    logic [15:0] issued_q, issued_d;
    logic done_q, done_d;
    logic last_inst, last_tri;
    assign last_inst = ({1'b0, i_q} + 1'b1) == icnt_q;
    assign last_tri = (k_q + 1'b1) == tcnt_q;
    always_comb begin
        state_d = state_q;
        icnt_d = icnt_q;
        i_d = i_q;
        base_d = base_q;
        tcnt_d = tcnt_q;
        k_d = k_q;
        issued_d = issued_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (frame_start && !abort) begin
                icnt_d = inst_count;
                issued_d = '0;
                i_d = IIDX_W'(1);
                state_d = inst_count <= 1 ? DONE : FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                base_d = inst_tri_base;
                tcnt_d = inst_tri_cnt;
                k_d = '0;
                if (inst_tri_cnt != 0) state_d = EMIT;
                else if (last_inst) state_d = DONE;
                else begin
                    i_d = i_q + 1'b1;
                    state_d = FETCH;
                end
            end
            EMIT: if (tri_ready) begin
                k_d = k_q + 1'b1;
                issued_d = issued_q == 16'hFFFF ? issued_q : issued_q + 16'd1;
                if (last_tri && last_inst) state_d = DONE;
                else if (last_tri) begin
                    i_d = i_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort overrides every transition but a same-cycle handshake still counts
        if (abort) begin
            state_d = IDLE;
            done_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            icnt_q <= '0;
            i_q <= '0;
            base_q <= '0;
            tcnt_q <= '0;
            k_q <= '0;
            issued_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q <= icnt_d;
            i_q <= i_d;
            base_q <= base_d;
            tcnt_q <= tcnt_d;
            k_q <= k_d;
            issued_q <= issued_d;
            done_q <= done_d;
        end
    end
    // frame_done is registered off DONE, so it lands the cycle after DONE
    assign frame_done = done_q;
    assign busy = state_q != IDLE;
    assign inst_rd_en = state_q == FETCH;
    assign inst_rd_addr = i_q;
    assign tri_valid = state_q == EMIT;
    assign tri_inst_id = i_q;
    assign tri_idx = base_q + k_q[TIDX_W-1:0];
    assign tri_last = tri_valid && last_tri;
    assign tri_issued = issued_q;
endmodule

// File: tb/tb_frame_tri_scheduler.sv
// tb_frame_tri_scheduler: directed and randomized frames against a job-list reference model.
module tb_frame_tri_scheduler;
    logic clk = 0, rst = 1, frame_start = 0, abort = 0, tri_ready = 1;
    logic [8:0] inst_count = 0;
    logic inst_rd_en, tri_valid, tri_last, busy, frame_done;
    logic [7:0] inst_rd_addr, tri_inst_id, tri_idx;
    logic [7:0] inst_tri_base = 0;
    logic [8:0] inst_tri_cnt = 0;
    logic [15:0] tri_issued;
    logic [7:0] base_tab [256];
    logic [8:0] cnt_tab [256];
    int checks = 0, errors = 0;

    frame_tri_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
        .inst_count(inst_count), .inst_rd_en(inst_rd_en), .inst_rd_addr(inst_rd_addr),
        .inst_tri_base(inst_tri_base), .inst_tri_cnt(inst_tri_cnt),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_inst_id(tri_inst_id),
        .tri_idx(tri_idx), .tri_last(tri_last), .busy(busy), .frame_done(frame_done),
        .tri_issued(tri_issued)
    );

    always #5 clk = ~clk;

    // instance table: data valid only the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        if (inst_rd_en) begin
            inst_tri_base <= base_tab[inst_rd_addr];
            inst_tri_cnt <= cnt_tab[inst_rd_addr];
        end else begin
            inst_tri_base <= 8'($urandom);
            inst_tri_cnt <= 9'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input int n, input bit rnd, input int ab_after, input bit ab_ready);
        int q_id[$], q_idx[$], q_last[$];
        int sum = 0, total = 0, fetch_i = 1, hs = 0, cyc = 0, done_cyc = -1, first_v = -1, ab_st = 0, spins = 0, extra = 0;
        bit stall = 0, fin = 0;
        logic [7:0] p_id = 0, p_idx = 0;
        logic p_last = 0;
        for (int i = 1; i < n; i++) begin
            sum += 2 + int'(cnt_tab[i]);
            for (int k = 0; k < int'(cnt_tab[i]); k++) begin
                q_id.push_back(i);
                q_idx.push_back((int'(base_tab[i]) + k) % 256);
                q_last.push_back(int'(k == int'(cnt_tab[i]) - 1));
            end
        end
        total = q_id.size();
        @(posedge clk); #1;
        frame_start = 1;
        inst_count = 9'(n);
        tri_ready = rnd ? 1'($urandom) : 1'b1;
        while (!fin && spins < 3000) begin
            @(negedge clk);
            if (ab_st == 2) begin
                chk("abort_valid", tri_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_issued", tri_issued, ab_after + int'(ab_ready));
                repeat (4) begin
                    @(negedge clk);
                    extra += int'(frame_done);
                end
                chk("abort_no_done", extra, 0);
                fin = 1;
            end else begin
                if (inst_rd_en) begin
                    chk("rd_addr", inst_rd_addr, fetch_i);
                    fetch_i++;
                end
                if (cyc == 1) chk("rd_en_T1", inst_rd_en, n > 1);
                if (stall) begin
                    chk("stall_valid", tri_valid, 1);
                    chk("stall_id", tri_inst_id, p_id);
                    chk("stall_idx", tri_idx, p_idx);
                    chk("stall_last", tri_last, p_last);
                end
                if (tri_valid && first_v < 0) begin
                    first_v = cyc;
                    if (!rnd && cnt_tab[1] != 0) chk("first_valid_T3", cyc, 3);
                end
                if (tri_valid && tri_ready) begin
                    chk("job_avail", q_id.size() > 0, 1);
                    if (q_id.size() > 0) begin
                        chk("job_id", tri_inst_id, q_id.pop_front());
                        chk("job_idx", tri_idx, q_idx.pop_front());
                        chk("job_last", tri_last, q_last.pop_front());
                    end
                    hs++;
                end
                stall = tri_valid && !tri_ready;
                p_id = tri_inst_id;
                p_idx = tri_idx;
                p_last = tri_last;
                if (frame_done) begin
                    done_cyc = cyc;
                    fin = 1;
                end
            end
            if (!fin) begin
                @(posedge clk); #1;
                frame_start = 0;
                abort = 0;
                cyc++;
                spins++;
                inst_count = 9'($urandom);
                tri_ready = rnd ? 1'($urandom) : 1'b1;
                if (rnd && cyc == 4 && busy) frame_start = 1;
                if (ab_st == 1) ab_st = 2;
                if (ab_after > 0 && ab_st == 0 && hs == ab_after) begin
                    abort = 1;
                    tri_ready = ab_ready;
                    ab_st = 1;
                end
            end
        end
        chk("frame_end", fin, 1);
        if (ab_after <= 0) begin
            chk("frame_done_seen", done_cyc >= 0, 1);
            chk("jobs_left", q_id.size(), 0);
            chk("issued", tri_issued, total);
            chk("fetches", fetch_i, n > 1 ? n : 1);
            if (!rnd) chk("done_cycle", done_cyc, 2 + sum);
            @(negedge clk);
            chk("done_one_pulse", frame_done, 0);
            chk("idle_after", busy, 0);
        end
    endtask

    initial begin
        int dn;
        for (int i = 0; i < 256; i++) begin
            base_tab[i] = 0;
            cnt_tab[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_valid", tri_valid, 0);
        chk("rst_last", tri_last, 0);
        chk("rst_id_idx", {tri_inst_id, tri_idx}, 0);
        chk("rst_rd", {inst_rd_en, inst_rd_addr}, 0);
        chk("rst_busy_done", {busy, frame_done}, 0);
        chk("rst_issued", tri_issued, 0);
        rst = 0;
        // two instances, mixed lengths
        base_tab[1] = 0; cnt_tab[1] = 1; base_tab[2] = 5; cnt_tab[2] = 2;
        run_frame(3, 0, -1, 0);
        // triangle index wraps at the buffer depth
        base_tab[1] = 254; cnt_tab[1] = 3;
        run_frame(2, 0, -1, 0);
        // empty instance skipped
        cnt_tab[1] = 0; base_tab[2] = 7; cnt_tab[2] = 1;
        run_frame(3, 0, -1, 0);
        // camera-only and empty frames
        run_frame(1, 0, -1, 0);
        run_frame(0, 0, -1, 0);
        // random tables with random backpressure
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 1; i < n; i++) begin
                base_tab[i] = 8'($urandom);
                cnt_tab[i] = 9'($urandom_range(0, 4));
            end
            run_frame(n, 1, -1, 0);
        end
        // abort after the second handshake, then a normal frame
        base_tab[1] = 10; cnt_tab[1] = 4;
        run_frame(2, 0, 2, 0);
        run_frame(2, 0, -1, 0);
        // abort coinciding with a handshake still counts it
        run_frame(2, 0, 2, 1);
        // abort beats frame_start in IDLE
        @(posedge clk); #1;
        frame_start = 1; abort = 1; inst_count = 5;
        @(posedge clk); #1;
        frame_start = 0; abort = 0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rd", inst_rd_en, 0);
        chk("idle_abort_issued", tri_issued, 3);
        // reset in the middle of a walk
        base_tab[1] = 1; cnt_tab[1] = 3; base_tab[2] = 9; cnt_tab[2] = 3;
        @(posedge clk); #1;
        frame_start = 1; inst_count = 3;
        @(posedge clk); #1;
        frame_start = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", tri_valid, 0);
        chk("mid_rst_issued", tri_issued, 0);
        @(negedge clk);
        rst = 0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(frame_done) + int'(busy);
        end
        chk("mid_rst_quiet", dn, 0);
        run_frame(3, 0, -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_tri_scheduler.md
FRAME_TRI_SCHEDULER -- requirements
Module: frame_tri_scheduler

Interface
REQ-001 SHALL have parameter MAX_INST, default 256: instance table depth; instance 0 is the camera.
REQ-002 SHALL have parameter MAX_TRI_CNT, default 256: triangle buffer depth.
REQ-003 SHALL have derived parameters IIDX_W = $clog2(MAX_INST) and TIDX_W = $clog2(MAX_TRI_CNT).
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1: one-cycle request to start a frame walk.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the current walk.
REQ-008 SHALL have port inst_count, input, IIDX_W+1: number of valid instances, camera included.
REQ-009 SHALL have port inst_rd_en, output, 1: instance table read strobe.
REQ-010 SHALL have port inst_rd_addr, output, IIDX_W: instance index being read.
REQ-011 SHALL have port inst_tri_base, input, TIDX_W: first triangle of the instance; valid the cycle after inst_rd_en.
REQ-012 SHALL have port inst_tri_cnt, input, TIDX_W+1: triangle count of the instance; same timing as inst_tri_base.
REQ-013 SHALL have port tri_valid, output, 1: triangle job valid.
REQ-014 SHALL have port tri_ready, input, 1: downstream transform stage accepts the job.
REQ-015 SHALL have port tri_inst_id, output, IIDX_W: instance of the job.
REQ-016 SHALL have port tri_idx, output, TIDX_W: triangle buffer index of the job.
REQ-017 SHALL have port tri_last, output, 1: job is the last triangle of its instance.
REQ-018 SHALL have port busy, output, 1: asserted in any state other than IDLE.
REQ-019 SHALL have port frame_done, output, 1: one-cycle pulse at normal completion of a frame.
REQ-020 SHALL have port tri_issued, output, 16: saturating count of handshakes in the current or last frame.

Function
REQ-021 SHALL implement the states IDLE, FETCH, WAIT, EMIT and DONE.
REQ-022 IDLE SHALL, on frame_start, latch inst_count, clear tri_issued, and set inst index i=1.
REQ-023 From IDLE on frame_start, SHALL go to DONE if latched inst_count<=1, otherwise to FETCH.
REQ-024 FETCH SHALL assert inst_rd_en=1 with inst_rd_addr=i for exactly one cycle, then go to WAIT.
REQ-025 WAIT SHALL latch inst_tri_base and inst_tri_cnt, then:
  - if cnt=0 and i=inst_count-1, go to DONE;
  - if cnt=0 otherwise, increment i and go to FETCH;
  - if cnt>0, clear the triangle counter k and go to EMIT.
REQ-026 In EMIT, tri_valid=1, tri_inst_id=i, tri_idx=(base+k) mod MAX_TRI_CNT (TIDX_W wrap), and tri_last=(k=cnt-1).
REQ-027 In EMIT, tri_valid and all payload outputs SHALL remain stable until the cycle in which tri_ready=1.
REQ-028 On an EMIT handshake SHALL increment k and tri_issued (saturating at 16'hFFFF), and:
  - if not last, stay in EMIT; with tri_ready held high, one job is issued per cycle;
  - if last and i=inst_count-1, go to DONE;
  - if last otherwise, increment i and go to FETCH.
REQ-029 DONE SHALL assert frame_done=1 for one cycle, then go to IDLE.
REQ-030 Latency from frame_start (cycle T) SHALL be: inst_rd_en at T+1, first tri_valid at T+3.
REQ-031 Per-instance overhead SHALL be 2 cycles (FETCH, WAIT).
REQ-032 frame_start while busy=1 SHALL be ignored.
REQ-033 Changes to inst_count during a walk SHALL have no effect on that walk.
REQ-034 abort in any non-IDLE state SHALL force IDLE next cycle, deassert tri_valid, and produce no frame_done.
REQ-035 abort SHALL keep tri_issued at its current value.
REQ-036 If abort and frame_start are both high in IDLE, abort SHALL win and no walk starts.
REQ-037 If abort and a handshake occur in the same cycle, the handshake SHALL count (tri_issued increments) and the state SHALL still go to IDLE.
REQ-038 inst_rd_en SHALL be 0 in every state except FETCH.
REQ-039 tri_valid SHALL be 0 in every state except EMIT.

Reset
REQ-040 On rst=1, SHALL immediately enter IDLE asynchronously.
REQ-041 On rst=1, SHALL set to 0: tri_valid, tri_last, tri_inst_id, tri_idx, inst_rd_en, inst_rd_addr, busy, frame_done, tri_issued and all internal counters.
REQ-042 Reset asserted mid-frame SHALL discard the walk; after release no frame_done is produced until a new frame_start.

Verification
REQ-043 inst_count=3; inst1 base=0 cnt=1; inst2 base=5 cnt=2; tri_ready=1 -> jobs (1,0,last=1), (2,5,last=0), (2,6,last=1); tri_issued=3; one frame_done pulse; first tri_valid at T+3.
REQ-044 inst_count=2; inst1 base=254 cnt=3 -> tri_idx 254, 255, 0, with tri_last only on the job with tri_idx=0.
REQ-045 inst_count=3; inst1 cnt=0; inst2 cnt=1 base=7 -> instance 1 skipped; single job (2,7,last=1); frame_done follows.
REQ-046 inst_count=1, then inst_count=0 -> no inst_rd_en, no tri_valid, frame_done at T+2 in each case.
REQ-047 tri_ready toggled randomly -> payload stable while stalled; no job dropped or duplicated; a frame_start while busy is ignored.
REQ-048 abort after the 2nd handshake of a 4-triangle frame -> tri_valid=0 next cycle, no frame_done, tri_issued=2; a subsequent frame_start runs normally.
